// File: rtl/alu_control.sv
// ALU control decoder: maps the main-control operation class and R-type func
// field to a 3-bit ALU control word, registered with one cycle of latency.
module alu_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] func,
  input  logic [2:0] alu_op,
  output logic [2:0] alu_ctr,
  output logic       illegal
);

  typedef enum logic [2:0] {
    CTR_AND = 3'b000,
    CTR_ADD = 3'b001,
    CTR_SUB = 3'b010,
    CTR_XOR = 3'b011,
    CTR_NOR = 3'b100,
    CTR_OR  = 3'b101,
    CTR_SLT = 3'b110
  } alu_ctr_e;

  typedef enum logic [2:0] {
    OP_MEM   = 3'b000,
    OP_RTYPE = 3'b001,
    OP_BRANCH= 3'b010,
    OP_ANDI  = 3'b011,
    OP_ORI   = 3'b100,
    OP_SLTI  = 3'b101,
    OP_RSV6  = 3'b110,
    OP_RSV7  = 3'b111
  } alu_op_e;

  alu_ctr_e ctr_next;
  logic     illegal_next;
  alu_ctr_e func_ctr;
  logic     func_bad;

  // R-type func values 000..110 equal their control encodings; 111 is undefined.
  always_comb begin
    func_ctr = CTR_ADD;
    func_bad = 1'b0;
    unique case (func)
      3'b000:  func_ctr = CTR_AND;
      3'b001:  func_ctr = CTR_ADD;
      3'b010:  func_ctr = CTR_SUB;
      3'b011:  func_ctr = CTR_XOR;
      3'b100:  func_ctr = CTR_NOR;
      3'b101:  func_ctr = CTR_OR;
      3'b110:  func_ctr = CTR_SLT;
      default: begin
        func_ctr = CTR_ADD;
        func_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    ctr_next     = CTR_ADD;
    illegal_next = 1'b0;
    unique case (alu_op_e'(alu_op))
      OP_MEM:    ctr_next = CTR_ADD;
      OP_RTYPE: begin
        ctr_next     = func_ctr;
        illegal_next = func_bad;
      end
      OP_BRANCH: ctr_next = CTR_SUB;
      OP_ANDI:   ctr_next = CTR_AND;
      OP_ORI:    ctr_next = CTR_OR;
      OP_SLTI:   ctr_next = CTR_SLT;
      default: begin
        ctr_next     = CTR_ADD;
        illegal_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_ctr <= CTR_ADD;
      illegal <= 1'b0;
    end else begin
      alu_ctr <= ctr_next;
      illegal <= illegal_next;
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// Scoreboard bench for alu_control: stimulus pushes expected results from a
// mnemonic-level reference model; a monitor pops and checks each cycle.
module tb_alu_control;

  logic       clk;
  logic       reset;
  logic [2:0] func;
  logic [2:0] alu_op;
  logic [2:0] alu_ctr;
  logic       illegal;

  alu_control dut (
    .clk     (clk),
    .reset   (reset),
    .func    (func),
    .alu_op  (alu_op),
    .alu_ctr (alu_ctr),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ctr;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model in terms of operation mnemonics.
  string op_name [8] = '{"ADD", "RTYPE", "SUB", "AND", "OR", "SLT", "BAD", "BAD"};
  string fn_name [8] = '{"AND", "ADD", "SUB", "XOR", "NOR", "OR", "SLT", "BAD"};
  string ctr_name[7] = '{"AND", "ADD", "SUB", "XOR", "NOR", "OR", "SLT"};

  function automatic exp_t model(input bit rst, input bit [2:0] op, input bit [2:0] fn);
    exp_t  e;
    string m;
    e.ctr = 3'd1;
    e.ill = 1'b0;
    if (rst) return e;
    m = op_name[op];
    if (m == "RTYPE") m = fn_name[fn];
    if (m == "BAD") begin
      e.ill = 1'b1;
      return e;
    end
    for (int i = 0; i < 7; i++)
      if (ctr_name[i] == m) e.ctr = 3'(i);
    return e;
  endfunction

  task automatic apply(input bit rst, input bit [2:0] op, input bit [2:0] fn);
    @(posedge clk);
    #2;
    reset  = rst;
    alu_op = op;
    func   = fn;
    exp_q.push_back(model(rst, op, fn));
  endtask

  task automatic check(input string name, input logic [2:0] ctr, input logic ill);
    tests++;
    if (alu_ctr !== ctr || illegal !== ill) begin
      fails++;
      $display("FAIL %s: got alu_ctr=%b illegal=%b, expected alu_ctr=%b illegal=%b",
               name, alu_ctr, illegal, ctr, ill);
    end
  endtask

  // Monitor: check just after each edge, then again after inputs have moved
  // to confirm the output did not follow the inputs combinationally.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("post_edge", e.ctr, e.ill);
        #4;
        check("mid_cycle_hold", e.ctr, e.ill);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    alu_op = 3'b001;
    func   = 3'b010;

    apply(1'b1, 3'b001, 3'b010);
    apply(1'b1, 3'b001, 3'b010);
    apply(1'b0, 3'b001, 3'b010);

    for (int f = 0; f < 7; f++)
      apply(1'b0, 3'b001, 3'(f));

    apply(1'b0, 3'b001, 3'b111);
    apply(1'b0, 3'b001, 3'b000);

    apply(1'b0, 3'b000, 3'b011);
    apply(1'b0, 3'b010, 3'b011);
    apply(1'b0, 3'b011, 3'b011);
    apply(1'b0, 3'b100, 3'b011);
    apply(1'b0, 3'b101, 3'b011);

    apply(1'b0, 3'b110, 3'b000);
    apply(1'b0, 3'b111, 3'b101);

    // Reset mid-stream discards the pending decode.
    apply(1'b0, 3'b010, 3'b000);
    apply(1'b1, 3'b010, 3'b000);
    apply(1'b0, 3'b101, 3'b000);

    for (int n = 0; n < 400; n++)
      apply(($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    repeat (3) @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
